amo_mem_responder: RTL and testbench
====================================

Name: amo_mem_responder

Overview:
Memory-side responder for RISC-V A-extension traffic; the slave end of the CPU's atomic request path. Accepts one request at a time (load, store, LR.W, SC.W, AMO*.W) over a valid/ready channel. Performs the read, modify and write sequence against a single-port memory/bus slave and returns the response over a valid/ready channel. Holds the authoritative LR/SC reservation, so stores from any master entering through this port break it.

Parameters:
ADDR_W, 32, request/memory address width
RESV_GRAN_LOG2, 2, log2 of reservation granule in bytes; address bits below this are ignored in match

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept (high only in IDLE)
req_is_lr  in  1  LR.W
req_is_sc  in  1  SC.W
req_is_amo  in  1  AMO (non-LR/SC)
req_is_store  in  1  plain store (ignored if any atomic flag set)
req_amo_op  in  5  funct7[31:27] operation code
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store/SC/AMO source data (rs2)
req_wstrb  in  4  byte strobes for plain store; atomics always use 4'hF
resp_valid  out  1  response present
resp_ready  in  1  requester accepts response
resp_rdata  out  32  load data / LR data / AMO old value / SC status (0 = success, 1 = fail)
resp_err  out  1  access fault or misaligned atomic
mem_req  out  1  memory access request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address
mem_wdata  out  32  write data
mem_wstrb  out  4  write strobes
mem_ack  in  1  access complete (read data valid this cycle)
mem_rdata  in  32  read data
mem_err  in  1  bus error, qualified by mem_ack
resv_clear  in  1  external reservation kill (trap, context switch)
resv_valid_o  out  1  reservation status (debug/visibility)

Behaviour:
- Reset (async): state IDLE, resv valid = 0, resv addr = 0, resp_valid = 0, mem_req = 0, resp_rdata = 0, resp_err = 0. req_ready = 1 once reset releases.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: on req_valid && req_ready, latch all req_* fields.
- Kind priority on latch: lr > sc > amo > store > load.
- Misaligned atomic (addr[1:0] != 0): go to RESP with err = 1, rdata = 0, no memory access, reservation cleared.
- Next state from IDLE:
  - load, LR, AMO -> RD.
  - store -> WR.
  - SC -> WR if reservation valid and granule matches, else RESP with rdata = 1.
  - Every accepted SC clears the reservation in the accept cycle, regardless of outcome.
- RD: mem_req = 1, mem_we = 0. Hold all mem_* outputs stable until mem_ack.
  - On ack with mem_err: go to RESP, err = 1, rdata = 0, no write; LR does not set the reservation.
  - On ack, load or LR: go to RESP with rdata = mem_rdata. LR sets resv valid = 1 and resv addr = req_addr.
  - On ack, AMO: latch old value, compute the result from old value and wdata, go to WR.
- AMO arithmetic is 32-bit wrapping:
  - swap; add (mod 2^32); xor; and; or.
  - min/max compare signed; minu/maxu compare unsigned.
  - Undefined op behaves as swap.
- WR: mem_req = 1, mem_we = 1. Strobes are req_wstrb for a plain store, 4'hF otherwise. Data is wdata, or the AMO result for an AMO.
  - On ack: go to RESP. rdata is the AMO old value, 0 for SC/store; err = mem_err.
  - A failed AMO write still returns err = 1 with the old value.
- Any completed write (store, SC, AMO) whose granule matches resv addr clears resv valid.
- resv_clear clears resv valid in any state.
- A resv_clear in the same cycle as an LR completing leaves the reservation invalid (clear wins).
- RESP: resp_valid = 1 with rdata/err held stable until resp_ready, then go to IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency with zero-wait memory (mem_ack in the first request cycle), accept at cycle T:
  - load: mem_req at T+1, resp_valid at T+2.
  - AMO: RD at T+1, WR at T+2, resp_valid at T+3.
- rst mid-transaction: drops mem_req and resp_valid immediately, reservation invalid. The memory side must tolerate the abandoned request.

Decomposition:
- amo_pkg:
  - AMO op localparams (00000 add, 00001 swap, 00010 lr, 00011 sc, 00100 xor, 01000 or, 01100 and, 10000 min, 10100 max, 11000 minu, 11100 maxu).
  - FSM state encoding.
  - Request-kind encoding.
- Sub-module amo_alu: purely combinational (op, old, src) -> result. Reusable by CPU-side logic.

Test Plan:
- Zero-wait memory, AMOADD at addr 0x100, mem = 0x7FFF_FFFF, wdata = 1 -> write 0x8000_0000, resp_rdata = 0x7FFF_FFFF, resp_valid at T+3.
- AMOMIN mem 0xFFFF_FFFF vs 0x1 -> writes 0xFFFF_FFFF. AMOMINU on the same operands -> writes 0x1.
- LR 0x200 then SC 0x200 wdata 0xA5 -> write 0xA5, rdata 0. Second SC 0x200 -> no mem_req, rdata 1.
- LR 0x200, plain store to 0x202 (wstrb 4'b0100), SC 0x200 -> SC fails with rdata 1. Repeat with store to 0x204 -> SC succeeds.
- mem_ack delayed 3 cycles with resp_ready low 2 cycles -> mem_*/resp_* outputs stable throughout, req_ready low until the handshake completes.
- AMOSWAP at 0x102 -> resp_err = 1, no mem_req. AMO read with mem_err -> resp_err = 1, no write phase. Async rst asserted in WR -> mem_req = 0 that cycle, resv_valid_o = 0.

Source files
------------

// File: rtl/amo_pkg.sv
// ---------------------------------------------------------------------------
// amo_pkg: shared encodings for the atomic memory responder and its ALU.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package amo_pkg;

  // funct7[31:27] operation codes of the A extension
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_LOAD  = 3'd0,
    K_STORE = 3'd1,
    K_LR    = 3'd2,
    K_SC    = 3'd3,
    K_AMO   = 3'd4
  } kind_t;

endpackage

`default_nettype wire

// File: rtl/amo_alu.sv
// ---------------------------------------------------------------------------
// amo_alu: combinational AMO*.W result from old memory value and rs2.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module amo_alu
  import amo_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] src,
  output logic [31:0] result
);

  always_comb begin
    result = src;
    case (op)
      AMO_ADD:  result = old + src;
      AMO_XOR:  result = old ^ src;
      AMO_OR:   result = old | src;
      AMO_AND:  result = old & src;
      AMO_MIN:  result = ($signed(old) < $signed(src)) ? old : src;
      AMO_MAX:  result = ($signed(old) > $signed(src)) ? old : src;
      AMO_MINU: result = (old < src) ? old : src;
      AMO_MAXU: result = (old > src) ? old : src;
      // swap and any unassigned code write rs2 unchanged
      default:  result = src;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/amo_mem_responder.sv
// ---------------------------------------------------------------------------
// amo_mem_responder: memory-side load/store/LR/SC/AMO executor that owns
// the LR/SC reservation. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module amo_mem_responder
  import amo_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int RESV_GRAN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_lr,
  input  logic              req_is_sc,
  input  logic              req_is_amo,
  input  logic              req_is_store,
  input  logic [4:0]        req_amo_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  input  logic              resv_clear,
  output logic              resv_valid_o
);

  localparam int TAG_W = ADDR_W - RESV_GRAN_LOG2;

  state_t state, state_nxt;

  kind_t             kind_q;
  logic [4:0]        op_q;
  logic [ADDR_W-1:2] waddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       old_q;
  logic [31:0]       result_q;
  logic              resv_valid;
  logic [TAG_W-1:0]  resv_tag;

  kind_t             req_kind;
  logic              accept;
  logic              misaligned;
  logic              sc_ok;
  logic [TAG_W-1:0]  req_tag;
  logic              wr_hits_resv;
  logic [31:0]       alu_result;

  amo_alu u_alu (
    .op     (op_q),
    .old    (mem_rdata),
    .src    (wdata_q),
    .result (alu_result)
  );

  always_comb begin
    req_kind = K_LOAD;
    if (req_is_lr)         req_kind = K_LR;
    else if (req_is_sc)    req_kind = K_SC;
    else if (req_is_amo)   req_kind = K_AMO;
    else if (req_is_store) req_kind = K_STORE;
  end

  assign req_ready    = (state == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign misaligned   = (req_kind == K_LR || req_kind == K_SC || req_kind == K_AMO)
                        && (req_addr[1:0] != 2'b00);
  assign req_tag      = req_addr[ADDR_W-1:RESV_GRAN_LOG2];
  assign sc_ok        = resv_valid && (resv_tag == req_tag);
  assign wr_hits_resv = (waddr_q[ADDR_W-1:RESV_GRAN_LOG2] == resv_tag);

  // Memory outputs come straight from latched request state, so they stay
  // stable for as long as the slave withholds mem_ack.
  assign mem_req      = (state == S_RD) || (state == S_WR);
  assign mem_we       = (state == S_WR);
  assign mem_addr     = {waddr_q, 2'b00};
  assign mem_wdata    = (kind_q == K_AMO) ? result_q : wdata_q;
  assign mem_wstrb    = (kind_q == K_STORE) ? wstrb_q : 4'hF;
  assign resp_valid   = (state == S_RESP);
  assign resv_valid_o = resv_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_nxt = S_RESP;
          end else begin
            case (req_kind)
              K_STORE: state_nxt = S_WR;
              K_SC:    state_nxt = sc_ok ? S_WR : S_RESP;
              default: state_nxt = S_RD;
            endcase
          end
        end
      end
      S_RD: begin
        if (mem_ack)
          state_nxt = (!mem_err && kind_q == K_AMO) ? S_WR : S_RESP;
      end
      S_WR: begin
        if (mem_ack) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q     <= K_LOAD;
      op_q       <= 5'd0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      old_q      <= 32'd0;
      result_q   <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            kind_q  <= req_kind;
            op_q    <= req_amo_op;
            waddr_q <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (misaligned) begin
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
            end else if (req_kind == K_SC && !sc_ok) begin
              resp_rdata <= 32'd1;
              resp_err   <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            if (mem_err) begin
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
            end else begin
              old_q      <= mem_rdata;
              result_q   <= alu_result;
              resp_rdata <= mem_rdata;
              resp_err   <= 1'b0;
            end
          end
        end
        S_WR: begin
          if (mem_ack) begin
            resp_rdata <= (kind_q == K_AMO) ? old_q : 32'd0;
            resp_err   <= mem_err;
          end
        end
        default: ;
      endcase
    end
  end

  // Later assignments take priority: external kill beats an LR completing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_valid <= 1'b0;
      resv_tag   <= '0;
    end else begin
      if (state == S_RD && mem_ack && !mem_err && kind_q == K_LR) begin
        resv_valid <= 1'b1;
        resv_tag   <= waddr_q[ADDR_W-1:RESV_GRAN_LOG2];
      end
      if (accept && (req_kind == K_SC || misaligned))
        resv_valid <= 1'b0;
      if (state == S_WR && mem_ack && wr_hits_resv)
        resv_valid <= 1'b0;
      if (resv_clear)
        resv_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_amo_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_amo_mem_responder: directed self-checking bench with a behavioural
// word memory on the mem_* port. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_amo_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_lr = 1'b0, req_is_sc = 1'b0, req_is_amo = 1'b0, req_is_store = 1'b0;
  logic [4:0]  req_amo_op = 5'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack, mem_err;
  logic [31:0] mem_rdata;
  logic        resv_clear = 1'b0;
  logic        resv_valid_o;

  amo_mem_responder #(.ADDR_W(32), .RESV_GRAN_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_lr(req_is_lr), .req_is_sc(req_is_sc), .req_is_amo(req_is_amo),
    .req_is_store(req_is_store), .req_amo_op(req_amo_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .resv_clear(resv_clear), .resv_valid_o(resv_valid_o)
  );

  always #5 clk = ~clk;

  // behavioural memory: ack after ack_delay waiting cycles
  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  logic        err_inject = 1'b0;
  int          wait_cnt = 0;
  int          req_cyc = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'd0;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_err   = mem_ack && err_inject;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req) req_cyc <= req_cyc + 1;
    if (pl_we) mem[pl_idx] <= pl_data;
    if (mem_req && mem_ack && mem_we && !err_inject) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= mem_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // one full transaction; lat = negedges after the accept edge until resp_valid
  task automatic do_req(input logic lr, input logic sc, input logic amo, input logic st,
                        input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int stall,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int unstable);
    int          n;
    logic        seen;
    logic [31:0] a0, r0;
    logic        e0;
    unstable = 0; seen = 1'b0; a0 = 32'd0; rdata = 32'd0; err = 1'b0;
    @(negedge clk);
    req_is_lr = lr; req_is_sc = sc; req_is_amo = amo; req_is_store = st;
    req_amo_op = op; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_is_lr = 1'b0; req_is_sc = 1'b0; req_is_amo = 1'b0; req_is_store = 1'b0;
    n = 0;
    while (!resp_valid && n < 60) begin
      @(negedge clk);
      n++;
      if (!resp_valid) begin
        if (req_ready) unstable++;
        if (mem_req) begin
          if (!seen) begin a0 = mem_addr; seen = 1'b1; end
          else if (mem_addr !== a0) unstable++;
        end
      end
    end
    lat = n;
    if (!resp_valid) begin
      check_val("resp_timeout", 32'd0, 32'd1);
    end else begin
      r0 = resp_rdata; e0 = resp_err;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!resp_valid || resp_rdata !== r0 || resp_err !== e0 || req_ready || mem_req)
          unstable++;
      end
      rdata = r0; err = e0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, uns, w0, q0;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resv", {31'd0, resv_valid_o}, 32'd0);
    check_val("rst_rdata_err", {resp_rdata[30:0], resp_err}, 32'd0);

    preload(8'h40, 32'h7FFF_FFFF);
    preload(8'h41, 32'hFFFF_FFFF);
    preload(8'h42, 32'hFFFF_FFFF);
    preload(8'h80, 32'h0000_1234);
    preload(8'hC0, 32'h0000_0C0C);

    // AMOADD wraps into the sign bit
    w0 = wr_cnt;
    do_req(0, 0, 1, 0, 5'b00000, 32'h100, 32'd1, 4'h0, 0, rd, er, lat, uns);
    check_val("amoadd_lat", lat, 3);
    check_val("amoadd_old", rd, 32'h7FFF_FFFF);
    check_val("amoadd_wdata", last_wdata, 32'h8000_0000);
    check_val("amoadd_wr_cnt", wr_cnt - w0, 1);

    do_req(0, 0, 1, 0, 5'b10000, 32'h104, 32'd1, 4'h0, 0, rd, er, lat, uns);
    check_val("amomin_mem", mem[8'h41], 32'hFFFF_FFFF);
    check_val("amomin_old", rd, 32'hFFFF_FFFF);
    do_req(0, 0, 1, 0, 5'b11000, 32'h108, 32'd1, 4'h0, 0, rd, er, lat, uns);
    check_val("amominu_mem", mem[8'h42], 32'h0000_0001);
    do_req(0, 0, 1, 0, 5'b10100, 32'h108, 32'hFFFF_FFFE, 4'h0, 0, rd, er, lat, uns);
    check_val("amomax_mem", mem[8'h42], 32'h0000_0001);
    do_req(0, 0, 1, 0, 5'b01100, 32'h104, 32'h0F0F_00FF, 4'h0, 0, rd, er, lat, uns);
    check_val("amoand_mem", mem[8'h41], 32'h0F0F_00FF);
    do_req(0, 0, 1, 0, 5'b00100, 32'h104, 32'hFFFF_0000, 4'h0, 0, rd, er, lat, uns);
    check_val("amoxor_mem", mem[8'h41], 32'hF0F0_00FF);

    do_req(0, 0, 0, 0, 5'b00000, 32'h100, 32'd0, 4'h0, 0, rd, er, lat, uns);
    check_val("load_lat", lat, 2);
    check_val("load_data", rd, 32'h8000_0000);

    // LR / SC success then a second SC must fail without touching memory
    do_req(1, 0, 0, 0, 5'b00010, 32'h200, 32'd0, 4'h0, 0, rd, er, lat, uns);
    check_val("lr_data", rd, 32'h0000_1234);
    check_val("lr_resv", {31'd0, resv_valid_o}, 32'd1);
    do_req(0, 1, 0, 0, 5'b00011, 32'h200, 32'hA5, 4'h0, 0, rd, er, lat, uns);
    check_val("sc1_status", rd, 32'd0);
    check_val("sc1_mem", mem[8'h80], 32'h0000_00A5);
    check_val("sc1_resv", {31'd0, resv_valid_o}, 32'd0);
    q0 = req_cyc;
    do_req(0, 1, 0, 0, 5'b00011, 32'h200, 32'h5A, 4'h0, 0, rd, er, lat, uns);
    check_val("sc2_status", rd, 32'd1);
    check_val("sc2_no_mem", req_cyc - q0, 0);

    // byte store in the same granule breaks the reservation
    do_req(1, 0, 0, 0, 5'b00010, 32'h200, 32'd0, 4'h0, 0, rd, er, lat, uns);
    do_req(0, 0, 0, 1, 5'b00000, 32'h202, 32'h00AB_0000, 4'b0100, 0, rd, er, lat, uns);
    check_val("store_lat", lat, 2);
    check_val("store_mem", mem[8'h80], 32'h00AB_00A5);
    do_req(0, 1, 0, 0, 5'b00011, 32'h200, 32'h77, 4'h0, 0, rd, er, lat, uns);
    check_val("sc_after_store_hit", rd, 32'd1);
    do_req(1, 0, 0, 0, 5'b00010, 32'h200, 32'd0, 4'h0, 0, rd, er, lat, uns);
    do_req(0, 0, 0, 1, 5'b00000, 32'h204, 32'h11, 4'b0001, 0, rd, er, lat, uns);
    do_req(0, 1, 0, 0, 5'b00011, 32'h200, 32'h77, 4'h0, 0, rd, er, lat, uns);
    check_val("sc_after_store_miss", rd, 32'd0);
    check_val("sc_after_store_mem", mem[8'h80], 32'h0000_0077);

    // external kill
    do_req(1, 0, 0, 0, 5'b00010, 32'h200, 32'd0, 4'h0, 0, rd, er, lat, uns);
    @(negedge clk); resv_clear = 1'b1;
    @(negedge clk); resv_clear = 1'b0;
    check_val("resv_clear", {31'd0, resv_valid_o}, 32'd0);
    do_req(0, 1, 0, 0, 5'b00011, 32'h200, 32'h99, 4'h0, 0, rd, er, lat, uns);
    check_val("sc_after_clear", rd, 32'd1);

    // slow memory plus a stalled response
    ack_delay = 3;
    do_req(0, 0, 0, 0, 5'b00000, 32'h100, 32'd0, 4'h0, 2, rd, er, lat, uns);
    check_val("stall_lat", lat, 5);
    check_val("stall_stable", uns, 0);
    check_val("stall_data", rd, 32'h8000_0000);
    @(negedge clk);
    check_val("stall_ready_after", {31'd0, req_ready}, 32'd1);
    ack_delay = 0;

    // misaligned atomic: error, no memory traffic
    q0 = req_cyc;
    do_req(0, 0, 1, 0, 5'b00001, 32'h102, 32'h1, 4'h0, 0, rd, er, lat, uns);
    check_val("misal_err", {31'd0, er}, 32'd1);
    check_val("misal_rdata", rd, 32'd0);
    check_val("misal_no_mem", req_cyc - q0, 0);

    // read error on an AMO skips the write phase
    err_inject = 1'b1;
    q0 = req_cyc;
    do_req(0, 0, 1, 0, 5'b00000, 32'h100, 32'd5, 4'h0, 0, rd, er, lat, uns);
    err_inject = 1'b0;
    check_val("rderr_err", {31'd0, er}, 32'd1);
    check_val("rderr_rdata", rd, 32'd0);
    check_val("rderr_one_cycle", req_cyc - q0, 1);
    check_val("rderr_mem", mem[8'h40], 32'h8000_0000);

    // async reset while in the write phase
    do_req(1, 0, 0, 0, 5'b00010, 32'h300, 32'd0, 4'h0, 0, rd, er, lat, uns);
    check_val("lr300_resv", {31'd0, resv_valid_o}, 32'd1);
    ack_delay = 3;
    @(negedge clk);
    req_is_amo = 1'b1; req_amo_op = 5'b00001; req_addr = 32'h104; req_wdata = 32'h1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_is_amo = 1'b0;
    begin
      int n;
      n = 0;
      while (!mem_we && n < 30) begin @(negedge clk); n++; end
      check_val("reach_wr", {31'd0, mem_we}, 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    check_val("rstwr_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rstwr_resv", {31'd0, resv_valid_o}, 32'd0);
    check_val("rstwr_resp_valid", {31'd0, resp_valid}, 32'd0);
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rstwr_ready", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
